rr_arbiter16: RTL and testbench
===============================

# rr_arbiter16

Round-robin arbiter granting one of 16 requesters access to a shared resource (a register-file write port or bus slot) addressed through the 4-to-16 decoder. It registers a 4-bit grant index and drives the decoded one-hot grant vector. It holds each grant until release, with an optional forced-release timeout. It sits between the requesting units and the decoder-selected resource in the MIPS datapath.

## Interface
- `MAX_HOLD`, default 8: maximum grant length in cycles, range 2..255; used only when the timeout feature is compiled in.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 16: request vector; bit i = requester i wants the resource.
- `done` input 1: current owner releases the grant this cycle.
- `grant` output 16: one-hot grant, equal to the 4-to-16 decode of `grant_idx` when `grant_valid`=1, otherwise 0.
- `grant_idx` output 4: index of current owner.
- `grant_valid` output 1: a grant is active.
- `timeout` output 1: one-cycle pulse when a grant was force-released by the hold limit.

## Operation
- FSM states: IDLE, GRANT, GAP.
- **IDLE**
  - If `req`≠0, select the winner by round-robin: the first set bit scanning upward from `last_idx`+1, wrapping 15→0.
  - Load `grant_idx`=winner, set `grant_valid`=1, clear the hold counter, go to GRANT.
  - If `req`=0, stay in IDLE.
- **GRANT**, release condition = `done`=1, OR `req[grant_idx]`=0, OR (timeout enabled AND hold counter = `MAX_HOLD`-1).
  - On release: `last_idx`←`grant_idx`, `grant_valid`←0, go to GAP. `timeout` pulses only when the counter caused the release and neither other condition was true.
  - Otherwise: hold counter +1 (saturating 8-bit).
- **GAP**: one dead cycle with all grant outputs 0 (decoder turnaround), then go to IDLE.
- `last_idx` updates only on release. A requester that drops `req` before its grant registers is simply skipped.
- Requests arriving in GRANT or GAP wait. No starvation: each requester waits at most 15 grants.
- `grant` is a combinational decode of registered `grant_idx`, gated by `grant_valid`. It is never multi-hot.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low): state=IDLE, `grant_valid`=0, `grant`=16'h0000, `grant_idx`=4'h0, `timeout`=0, hold counter=0, `last_idx`=4'hF so the first scan starts at bit 0.
- Latency: a `req` sampled in IDLE at edge k gives `grant_valid`=1 after edge k.
- Back-to-back grants are separated by exactly 2 cycles: the GAP cycle plus the IDLE evaluation cycle. Release at edge k gives the next grant at edge k+2.
- `done` is sampled only in GRANT. `done` in IDLE or GAP is ignored.
- Simultaneous `done` and timeout: release occurs and `timeout` stays 0.
- Reset asserted mid-grant: outputs clear immediately. After reset deassertion, scanning restarts from bit 0.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined: the hold counter forces release after `MAX_HOLD` cycles in GRANT and pulses `timeout`.
- `RR_ARB_TIMEOUT_EN` undefined: the counter logic is absent, `timeout` is tied to 0, and a grant persists until `done` or the owner's `req` drops.

## Test plan
- Reset: drive `req`=16'hFFFF with `rst_n`=0 → `grant`=0, `grant_valid`=0. Release reset → first grant `grant_idx`=0, `grant`=16'h0001 one cycle later.
- Round-robin: hold `req`=16'h8421, pulse `done` one cycle after each grant → grant order idx 0,5,10,15,0 with `grant` values 16'h0001, 16'h0020, 16'h0400, 16'h8000, 16'h0001, each separated by 2 idle cycles.
- Wrap: owner idx 14 releases with `req`=16'h4003 → next grant idx 0, not 1 or 14.
- Request drop: owner idx 3 deasserts `req[3]` without `done` → `grant_valid`=0 the next cycle; `timeout` stays 0.
- Timeout, with `RR_ARB_TIMEOUT_EN` and `MAX_HOLD`=8: hold `req[7]`=1 with no `done` → grant lasts exactly 8 cycles, `timeout` pulses once, and with only `req[7]` set, idx 7 is re-granted 2 cycles later. Without the macro, the grant persists for 100+ cycles.
- Mid-grant reset: assert `rst_n`=0 during an idx-9 grant → `grant`=0 asynchronously. After release with `req`=16'h0600 → grant idx 9 (scan from 0).

Source files
------------

// File: rtl/rr_arbiter16.sv
// rr_arbiter16 -- round-robin arbiter for 16 requesters sharing one resource.
//
// The winner index is registered and decoded to a one-hot grant vector. A grant
// is held until the owner signals done or drops its request. Every release is
// followed by one dead GAP cycle for decoder turnaround. The next grant is then
// evaluated in IDLE.
//
// Optional feature (compile-time macro RR_ARB_TIMEOUT_EN):
//   defined   : a hold counter force-releases a grant after MAX_HOLD cycles
//               and pulses timeout for one cycle.
//   undefined : no hold counter; timeout is tied to 0.
//
// Parameters:
//   MAX_HOLD    maximum grant length in cycles (2..255), timeout build only
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   req[15:0]   request vector, bit i = requester i wants the resource
//   done        current owner releases the grant (sampled only in GRANT)
//   grant[15:0] one-hot decode of grant_idx while grant_valid, else 0
//   grant_idx   index of the current owner
//   grant_valid a grant is active
//   timeout     one-cycle pulse when a grant was released by the hold limit
module rr_arbiter16 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic [3:0]  grant_idx,
    output logic        grant_valid,
    output logic        timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("rr_arbiter16: MAX_HOLD must be in 2..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] idx_r, idx_nxt;
    logic [3:0] last_r, last_nxt;
    logic       valid_r, valid_nxt;
    logic [3:0] winner;
    logic       rel_owner;
    logic       rel_hold;

    // Round-robin pick: scan offsets 16 down to 1 so that the smallest offset
    // above last_r with a set request is the final assignment. Offset 16 wraps
    // back onto last_r itself, so the previous owner is considered last.
    always_comb begin
        winner = last_r;
        for (int k = 16; k >= 1; k--) begin
            if (req[last_r + 4'(k)]) begin
                winner = last_r + 4'(k);
            end
        end
    end

    assign rel_owner = done || !req[idx_r];

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_r, hold_nxt;
    logic       to_r, to_nxt;

    assign rel_hold = (hold_r == 8'(MAX_HOLD - 1));
`else
    assign rel_hold = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx_r;
        last_nxt  = last_r;
        valid_nxt = valid_r;
`ifdef RR_ARB_TIMEOUT_EN
        hold_nxt  = hold_r;
        to_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    idx_nxt   = winner;
                    valid_nxt = 1'b1;
                    state_nxt = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_nxt  = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (rel_owner || rel_hold) begin
                    last_nxt  = idx_r;
                    valid_nxt = 1'b0;
                    state_nxt = GAP;
`ifdef RR_ARB_TIMEOUT_EN
                    // Only a release caused solely by the hold limit is reported.
                    to_nxt    = rel_hold && !rel_owner;
`endif
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    if (hold_r != 8'hFF) begin
                        hold_nxt = hold_r + 8'd1;
                    end
`endif
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx_r   <= 4'h0;
            last_r  <= 4'hF;  // first scan after reset starts at bit 0
            valid_r <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_r  <= 8'd0;
            to_r    <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            idx_r   <= idx_nxt;
            last_r  <= last_nxt;
            valid_r <= valid_nxt;
`ifdef RR_ARB_TIMEOUT_EN
            hold_r  <= hold_nxt;
            to_r    <= to_nxt;
`endif
        end
    end

    assign grant       = valid_r ? (16'h0001 << idx_r) : 16'h0000;
    assign grant_idx   = idx_r;
    assign grant_valid = valid_r;
`ifdef RR_ARB_TIMEOUT_EN
    assign timeout     = to_r;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus random traffic,
// all compared cycle by cycle against a behavioural owner/last/gap model.
module tb_rr_arbiter16;

    localparam int MAX_HOLD = 8;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: owner = -1 when nobody holds the resource.
    int m_owner;
    int m_last;
    int m_hold;
    bit m_gap;
    bit m_to;

    rr_arbiter16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = 15;
        m_hold  = 0;
        m_gap   = 1'b0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step(input logic [15:0] r, input logic d);
        bit rel_user;
        bit rel_cnt;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            rel_user = d || !r[m_owner];
            rel_cnt  = TO_EN && (m_hold == MAX_HOLD - 1);
            if (rel_user || rel_cnt) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1'b1;
                m_to    = rel_cnt && !rel_user;
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (r != 16'h0) begin
            for (int k = 1; k <= 16; k++) begin
                if (m_owner < 0 && r[(m_last + k) % 16]) m_owner = (m_last + k) % 16;
            end
            m_hold = 0;
        end
    endfunction

    task automatic compare_all();
        logic [15:0] eg;
        eg = 16'h0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check_eq("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        check_eq("grant", 32'(grant), 32'(eg));
        check_eq("timeout", 32'(timeout), 32'(m_to));
        if (m_owner >= 0) check_eq("grant_idx", 32'(grant_idx), 32'(m_owner));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked
    // 1 time unit after the next rising edge.
    task automatic step(input logic [15:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(r, d);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(16'h0, 1'b0);
        step(16'h0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0]  qi[$];
        logic [15:0] qg[$];
        logic        prev_v;
        int          run;
        int          pulses;
        bit          dropped;
        logic [15:0] r;
        logic [3:0]  exp_i [5];
        logic [15:0] exp_g [5];

        exp_i = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd0};
        exp_g = '{16'h0001, 16'h0020, 16'h0400, 16'h8000, 16'h0001};

        // Reset with all requests asserted
        rst_n = 1'b0;
        req   = 16'hFFFF;
        done  = 1'b0;
        model_reset();
        #1;
        check_eq("reset_grant", 32'(grant), 32'h0);
        check_eq("reset_valid", 32'(grant_valid), 32'h0);
        check_eq("reset_idx", 32'(grant_idx), 32'h0);
        step(16'hFFFF, 1'b0);
        step(16'hFFFF, 1'b0);
        rst_n = 1'b1;
        step(16'hFFFF, 1'b0);
        check_eq("first_grant", 32'(grant), 32'h0001);

        // Round-robin order over 0,5,10,15 with wrap
        do_reset();
        prev_v = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(16'h8421, logic'(m_owner >= 0));
            if (grant_valid && !prev_v) begin
                qi.push_back(grant_idx);
                qg.push_back(grant);
            end
            prev_v = grant_valid;
        end
        check_eq("rr_count", 32'(qi.size() >= 5), 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (i < qi.size()) begin
                check_eq("rr_idx", 32'(qi[i]), 32'(exp_i[i]));
                check_eq("rr_grant", 32'(qg[i]), 32'(exp_g[i]));
            end
        end

        // Wrap: owner 14 releases with req 4003 -> next owner 0
        do_reset();
        step(16'h4000, 1'b0);
        check_eq("wrap_owner14", 32'(grant_idx), 32'd14);
        step(16'h4000, 1'b0);
        step(16'h4003, 1'b1);
        step(16'h4003, 1'b0);
        step(16'h4003, 1'b0);
        check_eq("wrap_next_idx", 32'(grant_idx), 32'd0);
        check_eq("wrap_next_grant", 32'(grant), 32'h0001);

        // Request drop by owner 3
        do_reset();
        step(16'h0008, 1'b0);
        step(16'h0008, 1'b0);
        step(16'h0000, 1'b0);
        check_eq("drop_valid", 32'(grant_valid), 32'h0);
        check_eq("drop_timeout", 32'(timeout), 32'h0);
        step(16'h0000, 1'b0);

        // Hold limit on requester 7
        do_reset();
        run     = 0;
        pulses  = 0;
        dropped = 1'b0;
        for (int i = 0; i < 120; i++) begin
            step(16'h0080, 1'b0);
            if (timeout) pulses++;
            if (!dropped) begin
                if (grant_valid) run++;
                else if (run > 0) dropped = 1'b1;
            end
        end
        check_eq("hold_run_len", 32'(run), TO_EN ? 32'(MAX_HOLD) : 32'd120);
        check_eq("hold_pulses", 32'(pulses), TO_EN ? 32'd12 : 32'd0);

        // Asynchronous reset in the middle of an idx-9 grant
        do_reset();
        step(16'h0200, 1'b0);
        step(16'h0200, 1'b0);
        check_eq("mid_owner9", 32'(grant_idx), 32'd9);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_async_grant", 32'(grant), 32'h0);
        check_eq("mid_async_valid", 32'(grant_valid), 32'h0);
        step(16'h0600, 1'b0);
        step(16'h0600, 1'b0);
        rst_n = 1'b1;
        step(16'h0600, 1'b0);
        check_eq("mid_regrant_idx", 32'(grant_idx), 32'd9);

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = 16'($urandom & $urandom);
            if ($urandom_range(0, 7) == 0) r = 16'h0;
            step(r, logic'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
